// File: rtl/gpio_bus_sched.sv
// gpio_bus_sched: sequences APB3 host transfers and an interrupt-service
// engine onto the single GPIO register-file port. Round-robin arbitration in
// IDLE; all port and bus outputs are registered.
//
// Handshake: an APB transfer is requested when psel & penable are high. The
// bench/host must hold psel/penable/pwrite/paddr/pwdata stable until the one
// cycle in which pready=1, and treats that cycle as the transfer completion.
// pready is never high in any other cycle.
module gpio_bus_sched #(
  parameter int         RD_LAT   = 1,
  parameter int         HOLD_CYC = 2,
  parameter logic [7:0] MAX_ADR  = 8'h24
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        gpio_we,
  output logic [31:0] gpio_adr,
  output logic [31:0] gpio_dat_i,
  input  logic [31:0] gpio_dat_o,
  input  logic        gpio_inta_o,
  input  logic        auto_en,
  output logic [31:0] evt_data,
  output logic        evt_valid,
  input  logic        evt_ack,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    APB_WR   = 3'd1,
    APB_RD   = 3'd2,
    APB_ERR  = 3'd3,
    SVC_RD   = 3'd4,
    SVC_CLR  = 3'd5,
    SVC_HOLD = 3'd6
  } state_t;

  // Counter values: the last wait cycle of a read, the pready cycle of an
  // APB read, and the last guard cycle after an INTS clear.
  localparam logic [2:0]  RD_LAST   = 3'(RD_LAT - 1);
  localparam logic [2:0]  RD_DONE   = 3'(RD_LAT);
  localparam logic [2:0]  HOLD_LAST = 3'(HOLD_CYC - 1);
  localparam logic [31:0] INTS_ADR  = 32'h0000_001C;

  state_t     state;
  logic [2:0] cnt;
  logic       last_svc;   // 1 = the service engine was granted most recently

  logic apb_req;
  logic svc_req;
  logic grant_svc;
  logic grant_apb;
  logic addr_bad;
  logic capture;

  assign dbg_state = state;

  // Request decode and round-robin: on a tie the side not granted last wins.
  always_comb begin
    apb_req   = psel & penable;
    svc_req   = auto_en & gpio_inta_o;
    grant_svc = svc_req & (~apb_req | ~last_svc);
    grant_apb = apb_req & ~grant_svc;
    addr_bad  = (paddr > MAX_ADR) || (paddr[1:0] != 2'b00) ||
                (pwrite && (paddr == 8'h00));
    capture   = (state == SVC_RD) && (cnt == RD_LAST);
  end

  // Main sequencer: one registered FSM drives both the APB side and the
  // register port.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      last_svc   <= 1'b1;
      prdata     <= 32'd0;
      pready     <= 1'b0;
      pslverr    <= 1'b0;
      gpio_we    <= 1'b0;
      gpio_adr   <= 32'd0;
      gpio_dat_i <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 3'd0;
          if (grant_svc) begin
            last_svc <= 1'b1;
            gpio_adr <= INTS_ADR;
            state    <= SVC_RD;
          end else if (grant_apb) begin
            last_svc <= 1'b0;
            if (addr_bad) begin
              // Rejected access: complete at once, never touch the port.
              pready  <= 1'b1;
              pslverr <= 1'b1;
              prdata  <= 32'd0;
              state   <= APB_ERR;
            end else if (pwrite) begin
              gpio_we    <= 1'b1;
              gpio_adr   <= {24'd0, paddr};
              gpio_dat_i <= pwdata;
              pready     <= 1'b1;
              state      <= APB_WR;
            end else begin
              gpio_adr <= {24'd0, paddr};
              state    <= APB_RD;
            end
          end
        end

        APB_WR: begin
          gpio_we    <= 1'b0;
          gpio_dat_i <= 32'd0;
          pready     <= 1'b0;
          state      <= IDLE;
        end

        APB_ERR: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          state   <= IDLE;
        end

        APB_RD: begin
          if (cnt == RD_LAST) begin
            // Data is valid now; register it and complete next cycle.
            prdata <= gpio_dat_o;
            pready <= 1'b1;
            cnt    <= cnt + 3'd1;
          end else if (cnt == RD_DONE) begin
            pready <= 1'b0;
            cnt    <= 3'd0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end

        SVC_RD: begin
          if (cnt == RD_LAST) begin
            // Clear INTS right after the capture, same address.
            gpio_we    <= 1'b1;
            gpio_dat_i <= 32'd0;
            cnt        <= 3'd0;
            state      <= SVC_CLR;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end

        SVC_CLR: begin
          gpio_we <= 1'b0;
          cnt     <= 3'd0;
          state   <= SVC_HOLD;
        end

        SVC_HOLD: begin
          // Give the register file time to drop gpio_inta_o after the clear.
          if (cnt == HOLD_LAST) begin
            cnt   <= 3'd0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end

        default: begin
          gpio_we    <= 1'b0;
          gpio_dat_i <= 32'd0;
          pready     <= 1'b0;
          pslverr    <= 1'b0;
          cnt        <= 3'd0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // Event register: accumulate captured INTS bits until software-independent
  // logic acknowledges; an ack coinciding with a capture keeps only new bits.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      evt_data  <= 32'd0;
      evt_valid <= 1'b0;
    end else if (capture) begin
      evt_data  <= (evt_ack ? 32'd0 : evt_data) | gpio_dat_o;
      evt_valid <= 1'b1;
    end else if (evt_ack) begin
      evt_data  <= 32'd0;
      evt_valid <= 1'b0;
    end
  end

endmodule
